// File: rtl/fetch_unit.sv
// IF-stage fetch sequencer: drives the synchronous instruction memory and pairs each
// returned word with its PC. Define FETCH_MISALIGN_EN to trap misaligned redirects.
module fetch_unit #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [XLEN-1:0]  imem_pc,
    input  logic [XLEN-1:0]  imem_instr,
    input  logic             stall,
    input  logic             redirect,
    input  logic [XLEN-1:0]  redirect_pc,
    output logic [XLEN-1:0]  if_instr,
    output logic [XLEN-1:0]  if_pc,
    output logic             if_valid,
    output logic [CNT_W-1:0] fetch_count,
    output logic             fetch_misalign,
    output logic [XLEN-1:0]  fetch_badaddr
);

    logic [XLEN-1:0]  fetch_pc_reg, fetch_pc_next;
    logic [XLEN-1:0]  resp_pc_reg, resp_pc_next;
    logic             resp_valid_reg, resp_valid_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic             misalign_reg;
    logic [XLEN-1:0]  badaddr_reg;
    logic             redirect_act;
    logic             bad_redirect;

    // Once a misaligned redirect is trapped the stage is frozen until reset.
    assign redirect_act = redirect & ~misalign_reg;

`ifdef FETCH_MISALIGN_EN
    logic             misalign_next;
    logic [XLEN-1:0]  badaddr_next;

    assign bad_redirect = redirect_act & (redirect_pc[1:0] != 2'b00);

    always_comb begin
        misalign_next = misalign_reg;
        badaddr_next  = badaddr_reg;
        if (bad_redirect) begin
            misalign_next = 1'b1;
            badaddr_next  = redirect_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            misalign_reg <= 1'b0;
            badaddr_reg  <= '0;
        end else begin
            misalign_reg <= misalign_next;
            badaddr_reg  <= badaddr_next;
        end
    end
`else
    assign bad_redirect = 1'b0;
    assign misalign_reg = 1'b0;
    assign badaddr_reg  = '0;
`endif

    // During a stall the memory re-reads the held address so its output stays put.
    always_comb begin
        if (!rst_n)
            imem_pc = RESET_PC;
        else if (redirect_act)
            imem_pc = redirect_pc;
        else if (stall)
            imem_pc = resp_pc_reg;
        else
            imem_pc = fetch_pc_reg;
    end

    assign if_instr       = imem_instr;
    assign if_pc          = resp_pc_reg;
    assign if_valid       = resp_valid_reg & ~redirect & ~misalign_reg;
    assign fetch_count    = count_reg;
    assign fetch_misalign = misalign_reg;
    assign fetch_badaddr  = badaddr_reg;

    always_comb begin
        fetch_pc_next   = fetch_pc_reg;
        resp_pc_next    = resp_pc_reg;
        resp_valid_next = resp_valid_reg;
        count_next      = count_reg;
        if (!misalign_reg) begin
            if (bad_redirect) begin
                resp_valid_next = 1'b0;
            end else if (redirect_act) begin
                resp_pc_next    = redirect_pc;
                resp_valid_next = 1'b1;
                fetch_pc_next   = redirect_pc + XLEN'(4);
            end else if (!stall) begin
                resp_pc_next    = fetch_pc_reg;
                resp_valid_next = 1'b1;
                fetch_pc_next   = fetch_pc_reg + XLEN'(4);
            end
        end
        if (if_valid && !stall)
            count_next = count_reg + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_pc_reg   <= RESET_PC;
            resp_pc_reg    <= RESET_PC;
            resp_valid_reg <= 1'b0;
            count_reg      <= '0;
        end else begin
            fetch_pc_reg   <= fetch_pc_next;
            resp_pc_reg    <= resp_pc_next;
            resp_valid_reg <= resp_valid_next;
            count_reg      <= count_next;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized scoreboard bench for fetch_unit: an instruction-stream reference model
// predicts each cycle's IF output; a monitor process compares what the DUT presents.
module tb_fetch_unit;

    localparam int XLEN  = 32;
    localparam int CNT_W = 32;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [XLEN-1:0]  imem_pc;
    logic [XLEN-1:0]  imem_instr = '0;
    logic             stall = 1'b0;
    logic             redirect = 1'b0;
    logic [XLEN-1:0]  redirect_pc = '0;
    logic [XLEN-1:0]  if_instr;
    logic [XLEN-1:0]  if_pc;
    logic             if_valid;
    logic [CNT_W-1:0] fetch_count;
    logic             fetch_misalign;
    logic [XLEN-1:0]  fetch_badaddr;

    fetch_unit #(.XLEN(XLEN), .RESET_PC(32'h0), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .imem_pc(imem_pc), .imem_instr(imem_instr),
        .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .if_instr(if_instr), .if_pc(if_pc), .if_valid(if_valid),
        .fetch_count(fetch_count), .fetch_misalign(fetch_misalign),
        .fetch_badaddr(fetch_badaddr)
    );

    always #5 clk = ~clk;

    // Memory contents: word i holds 32'h1000_0000 + i; low address bits are dropped.
    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return 32'h1000_0000 + {2'b00, addr[31:2]};
    endfunction

    always @(posedge clk) imem_instr <= mem_word(imem_pc);

    typedef struct {
        bit          chk;
        bit          valid;
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] count;
        bit          mis;
        logic [31:0] bad;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model: the instruction currently presented and the next one in the stream.
    bit          m_known = 0;
    bit          m_shown;
    logic [31:0] m_pc, m_seq, m_count, m_bad;
    bit          m_mis;

    task automatic cyc(input bit r, input bit st, input bit rd, input logic [31:0] rpc);
        exp_t e;
        bit   vis;
        @(negedge clk);
        rst_n = r; stall = st; redirect = rd; redirect_pc = rpc;
        vis     = m_shown && !rd && !m_mis;
        e.chk   = m_known;
        e.valid = vis;
        e.pc    = m_pc;
        e.instr = mem_word(m_pc);
        e.count = m_count;
        e.mis   = m_mis;
        e.bad   = m_bad;
        exp_q.push_back(e);
        if (!r) begin
            m_known = 1; m_shown = 0; m_pc = 0; m_seq = 0;
            m_count = 0; m_mis = 0; m_bad = 0;
        end else if (m_mis) begin
            // frozen until reset
        end else if (rd) begin
`ifdef FETCH_MISALIGN_EN
            if (rpc[1:0] != 2'b00) begin
                m_mis = 1; m_bad = rpc; m_shown = 0;
            end else begin
                m_shown = 1; m_pc = rpc; m_seq = rpc + 4;
            end
`else
            m_shown = 1; m_pc = rpc; m_seq = rpc + 4;
`endif
        end else if (!st) begin
            if (vis) m_count = m_count + 1;
            m_shown = 1; m_pc = m_seq; m_seq = m_seq + 4;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: samples mid-cycle, after inputs settle and well away from the clock edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                if (e.chk) begin
                    check("if_valid", {31'b0, if_valid}, {31'b0, e.valid});
                    if (e.valid) begin
                        check("if_pc", if_pc, e.pc);
                        check("if_instr", if_instr, e.instr);
                        $display("[TB] deliver pc=%h instr=%h count=%0d", if_pc, if_instr, fetch_count);
                    end
                    check("fetch_count", fetch_count, e.count);
                    check("fetch_misalign", {31'b0, fetch_misalign}, {31'b0, e.mis});
                    check("fetch_badaddr", fetch_badaddr, e.bad);
                end
            end
        end
    end

    initial begin
        logic [31:0] rpc;
        bit r, st, rd;
        // Reset then straight-line run
        cyc(0, 0, 0, 0);
        cyc(0, 1, 1, 32'h44);
        repeat (3) cyc(1, 0, 0, 32'h1234);
        repeat (3) cyc(1, 1, 0, 0);          // stall while if_pc = 8
        cyc(1, 0, 0, 0);                      // resume at C
        cyc(1, 0, 1, 32'h40);                 // redirect while if_pc = C
        repeat (2) cyc(1, 0, 0, 0);
        cyc(1, 1, 1, 32'h80);                 // redirect beats stall
        repeat (2) cyc(1, 0, 0, 0);
        cyc(1, 0, 1, 32'h40);
        repeat (3) cyc(1, 0, 0, 0);
        cyc(0, 0, 0, 0);                      // mid-stream reset
        repeat (3) cyc(1, 0, 0, 0);
        cyc(1, 0, 1, 32'h42);                 // misaligned redirect
        repeat (2) cyc(1, 0, 0, 0);
        cyc(1, 0, 1, 32'h50);
        repeat (3) cyc(1, 0, 0, 0);
        cyc(0, 0, 0, 0);
        cyc(1, 0, 1, 32'hFFFF_FFF8);          // PC wrap
        repeat (4) cyc(1, 0, 0, 0);
        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            r  = ($urandom_range(0, 49) != 0);
            st = ($urandom_range(0, 3) == 0);
            rd = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 3) == 0)
                rpc = 32'hFFFF_FFF0 + {$urandom_range(0, 3), 2'b00};
            else
                rpc = {$urandom_range(0, 255), 2'b00};
            if ($urandom_range(0, 9) == 0)
                rpc[1:0] = 2'($urandom_range(1, 3));
            cyc(r, st, rd, rpc);
        end
        repeat (3) @(negedge clk);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch sequencer for the IF stage, on the address side of the synchronous-read instruction memory.
- Generates the fetch PC and tracks the one-cycle memory read latency.
- Pairs each returned word with its PC and valid bit for the IF/ID register.
- Handles hazard-unit stalls and EX-stage branch/jump redirects without duplicating or losing instructions.

Parameters:
- XLEN, 32, width of PC and instruction word.
- RESET_PC, 32'h0000_0000, first fetch address after reset; must be word aligned.
- CNT_W, 32, width of the delivered-instruction counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- imem_pc  output  XLEN  byte address to instruction memory; sampled by memory at posedge; combinational mux of internal registers.
- imem_instr  input  XLEN  instruction memory read data; corresponds to imem_pc sampled at the previous edge.
- stall  input  1  hazard unit: hold IF output, do not advance.
- redirect  input  1  taken branch/jump from EX; squash current fetch.
- redirect_pc  input  XLEN  redirect target byte address.
- if_instr  output  XLEN  instruction for IF/ID (= imem_instr).
- if_pc  output  XLEN  PC of if_instr.
- if_valid  output  1  if_instr is a real instruction; IF/ID latches when !stall.
- fetch_count  output  CNT_W  instructions delivered since reset.
- fetch_misalign  output  1  sticky misaligned-redirect flag (optional feature).
- fetch_badaddr  output  XLEN  offending redirect_pc (optional feature).

Behaviour:
- Registers:
  - fetch_pc: next address to request.
  - resp_pc: address whose data is on imem_instr.
  - resp_valid
  - fetch_count
- imem_pc priority:
  - !rst_n -> RESET_PC
  - else redirect -> redirect_pc
  - else stall -> resp_pc (re-read held word so imem_instr stays stable)
  - else fetch_pc
- Outputs:
  - if_instr = imem_instr
  - if_pc = resp_pc
  - if_valid = resp_valid & ~redirect; the wrong-path word is squashed in the same cycle.
- Reset (rst_n low at posedge):
  - fetch_pc <= RESET_PC
  - resp_pc <= RESET_PC
  - resp_valid <= 0
  - fetch_count <= 0
  - fetch_misalign <= 0
  - fetch_badaddr <= 0
  - Reset overrides stall and redirect.
  - Reset asserted mid-stream discards all in-flight state.
- Normal edge (no stall, no redirect):
  - resp_pc <= fetch_pc
  - resp_valid <= 1
  - fetch_pc <= fetch_pc + 4
- Latency: first valid instruction (PC = RESET_PC) appears 1 cycle after the first edge with rst_n high. Throughput is 1 instruction/cycle.
- Stall edge: fetch_pc, resp_pc and resp_valid all hold. Because the memory re-reads resp_pc, if_instr is unchanged next cycle. Stall while resp_valid = 0 keeps the stage empty.
- Redirect edge (overrides stall):
  - resp_pc <= redirect_pc
  - resp_valid <= 1
  - fetch_pc <= redirect_pc + 4
  - Target instruction is valid on the next cycle.
- PC arithmetic: modulo 2^XLEN, wraps silently at 32'hFFFF_FFFC -> 0.
- fetch_count: increments at edges where if_valid & ~stall & rst_n; wraps at 2^CNT_W.

Optional Feature:
- FETCH_MISALIGN_EN defined:
  - A redirect with redirect_pc[1:0] != 0 sets fetch_misalign <= 1 and fetch_badaddr <= redirect_pc.
  - resp_valid <= 0 and fetch_pc holds (no increment).
  - While fetch_misalign = 1: if_valid = 0, further redirects are ignored, fetch_count holds. Cleared only by reset.
- FETCH_MISALIGN_EN undefined:
  - redirect_pc low bits pass through unchecked; memory drops them.
  - fetch_misalign and fetch_badaddr are tied to 0.

Test Plan:
- Reset then run, memory preloaded word i = 32'h1000_0000+i -> after first active edge: if_pc 0,4,8,C with if_instr 1000_0000..1000_0003, if_valid = 1 every cycle; fetch_count = 4 after 4 delivery edges.
- Stall 3 cycles while if_pc = 8 -> if_pc = 8 and if_instr = 1000_0002 held for 4 cycles, fetch_count frozen, then resumes at C with no duplicate or skip.
- Redirect to 0x40 while if_pc = 0xC -> if_valid = 0 that cycle; next cycle if_pc = 0x40, then 0x44.
- Redirect and stall asserted together to 0x80 -> redirect wins; next cycle if_pc = 0x80, if_valid = 1.
- rst_n low for 1 cycle mid-stream at if_pc = 0x48 -> next cycle if_valid = 0, fetch_count = 0; then PCs restart at 0.
- With FETCH_MISALIGN_EN, redirect to 0x42 -> fetch_misalign = 1, fetch_badaddr = 0x42, if_valid stays 0; later redirect to 0x50 is ignored; without the macro, both flags stay 0.
